led_ctrl: RTL

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl_pkg.sv | 18 +
 rtl/led_ctrl_if.sv | 39 +++
 rtl/led_chan.sv | 79 +++++++
 rtl/led_ctrl.sv | 66 ++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED controller: channel mode encoding and sizing helpers.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the interface, the channel sub-module and the top.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    // Channel-index width; a single-channel build still carries a 1-bit index.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Configuration write port of the LED controller (valid/ready, one write per accept).
// No storage; purely wiring between a config master and led_ctrl.
// Backpressure: master holds cfg_valid and payload until it sees cfg_ready at an edge.
interface led_ctrl_if
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int CNT_W    = 24,
    parameter int DUTY_W   = 8
) ();

    localparam int CHAN_W = chan_w(NUM_LEDS);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    mode_t             cfg_mode;
    logic [CNT_W-1:0]  cfg_period;
    logic [DUTY_W-1:0] cfg_duty;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_mode,
        output cfg_period,
        output cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_mode,
        input  cfg_period,
        input  cfg_duty,
        output cfg_ready
    );

endinterface

// File: rtl/led_chan.sv
// One LED channel: mode/period/duty registers, prescaler, PWM step counter, registered LED bit.
// Latency: load/clr take effect at the same edge; led reflects the new mode from the next edge.
// Backpressure: none; load and clr are single-cycle strobes always honoured.
module led_chan
    import led_ctrl_pkg::*;
#(
    parameter int    CNT_W    = 24,
    parameter int    DUTY_W   = 8,
    parameter mode_t RST_MODE = MODE_BLINK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clr,
    input  mode_t             cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic              led
);

    localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(1) << (DUTY_W - 1);

    mode_t             mode;
    logic [CNT_W-1:0]  period;
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  pcnt;
    logic [DUTY_W-1:0] scnt;

    logic              tick;
    logic [CNT_W-1:0]  pcnt_nxt;
    logic [DUTY_W-1:0] scnt_nxt;
    logic              led_nxt;

    // Tick is the wrap cycle of the prescaler; period=0 ticks every cycle.
    always_comb begin
        tick     = (pcnt == period);
        pcnt_nxt = tick ? '0 : pcnt + 1'b1;
        scnt_nxt = scnt;
        led_nxt  = led;
        if (mode == MODE_PWM && tick) begin
            scnt_nxt = scnt + 1'b1;
        end
        case (mode)
            MODE_OFF:   led_nxt = 1'b0;
            MODE_ON:    led_nxt = 1'b1;
            MODE_BLINK: led_nxt = tick ? ~led : led;
            MODE_PWM:   led_nxt = (scnt < duty);
            default:    led_nxt = 1'b0;
        endcase
    end

    // A load also clears, so a simultaneous clr needs no separate handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= RST_MODE;
            period <= '0;
            duty   <= DUTY_RST;
            pcnt   <= '0;
            scnt   <= '0;
            led    <= 1'b0;
        end else if (load) begin
            mode   <= cfg_mode;
            period <= cfg_period;
            duty   <= cfg_duty;
            pcnt   <= '0;
            scnt   <= '0;
            led    <= 1'b0;
        end else if (clr) begin
            pcnt   <= '0;
            scnt   <= '0;
            led    <= 1'b0;
        end else begin
            pcnt   <= pcnt_nxt;
            scnt   <= scnt_nxt;
            led    <= led_nxt;
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED driver (off/on/blink/PWM) with a valid/ready config port; LED_CTRL_SYNC_EN adds sync_clr.
// Latency: accepted write loads its channel and clears that LED at the accept edge.
// Backpressure: cfg_ready drops for exactly one cycle after every accept, including discarded ones.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int CNT_W    = 24,
    parameter int DUTY_W   = 8,
    parameter int RST_MODE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef LED_CTRL_SYNC_EN
    input  logic                sync_clr,
`endif
    led_ctrl_if.slave           cfg,
    output logic [NUM_LEDS-1:0] led
);

    localparam int    CHAN_W  = chan_w(NUM_LEDS);
    localparam mode_t RST_M   = mode_t'(RST_MODE[1:0]);

    logic ready_q;
    logic accept;
    logic clr;

    assign accept        = cfg.cfg_valid && ready_q;
    assign cfg.cfg_ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= !accept;
        end
    end

`ifdef LED_CTRL_SYNC_EN
    assign clr = sync_clr;
`else
    assign clr = 1'b0;
`endif

    // Out-of-range indices match no instance, so such writes vanish after the handshake.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        logic load;
        assign load = accept && (cfg.cfg_chan == CHAN_W'(i));

        led_chan #(
            .CNT_W    (CNT_W),
            .DUTY_W   (DUTY_W),
            .RST_MODE (RST_M)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .clr        (clr),
            .cfg_mode   (cfg.cfg_mode),
            .cfg_period (cfg.cfg_period),
            .cfg_duty   (cfg.cfg_duty),
            .led        (led[i])
        );
    end

endmodule
